// File: rtl/triangle_setup_if.sv
// Triangle output bus between the setup stage and the rasterizer.
// Carries the valid/ready handshake, the vertex word, the clipped bounding
// box and the doubled area.
//   master : the setup stage (drives everything except tri_ready)
//   slave  : the rasterizer (drives tri_ready)
interface triangle_setup_if;
  logic        tri_valid;
  logic        tri_ready;
  logic [59:0] tri_data;
  logic [9:0]  bbox_xmin;
  logic [9:0]  bbox_xmax;
  logic [9:0]  bbox_ymin;
  logic [9:0]  bbox_ymax;
  logic [20:0] tri_area;

  modport master (
    output tri_valid, tri_data, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, tri_area,
    input  tri_ready
  );

  modport slave (
    input  tri_valid, tri_data, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, tri_area,
    output tri_ready
  );
endinterface

// File: rtl/triangle_setup.sv
// Triangle setup stage.
// Pops one triangle from the triangle FIFO RAM, computes its doubled signed
// area and screen-clipped bounding box, drops degenerate / off-screen
// triangles (counting them), and hands survivors to the rasterizer.
// Ports:
//   Clk, Reset   clock and synchronous active-high reset
//   fifo_empty   FIFO holds no triangle (sampled in IDLE only)
//   fifo_rd_en   one-cycle pop strobe
//   fifo_data    {y2,x2,y1,x1,y0,x0}, 10 bits each, valid one clock after the pop
//   tri_out      output bus (triangle_setup_if.master)
//   drop_cnt     saturating count of discarded triangles
// Optional feature macro: BACKFACE_CULL_EN
//   defined   : clockwise triangles (A<0) are dropped and counted
//   undefined : clockwise triangles are kept, vertices 1/2 swapped, area negated
module triangle_setup #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int CNT_W    = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  input  logic [59:0]         fifo_data,
  triangle_setup_if.master    tri_out,
  output logic [CNT_W-1:0]    drop_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] SETUP = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  localparam logic [10:0] X_LIM = 11'(SCREEN_W);
  localparam logic [10:0] Y_LIM = 11'(SCREEN_H);
  localparam logic [9:0]  X_MAX = 10'(SCREEN_W - 1);
  localparam logic [9:0]  Y_MAX = 10'(SCREEN_H - 1);

  logic [2:0] state_reg;
  logic [9:0] vx_reg [3];
  logic [9:0] vy_reg [3];

  // Vertex latch: the RAM word is valid while in WAIT.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_vert
      always_ff @(posedge Clk) begin
        if (Reset) begin
          vx_reg[gi] <= '0;
          vy_reg[gi] <= '0;
        end else if (state_reg == WAIT) begin
          vx_reg[gi] <= fifo_data[20*gi +: 10];
          vy_reg[gi] <= fifo_data[20*gi+10 +: 10];
        end
      end
    end
  endgenerate

  // Setup arithmetic on the latched vertices.
  logic signed [10:0] dx1, dy1, dx2, dy2;
  logic signed [21:0] prod_a, prod_b, area, area_neg;
  logic [9:0]  min_x, max_x, min_y, max_y;
  logic [9:0]  clip_xmax, clip_ymax;
  logic [20:0] area_abs;
  logic [59:0] out_data;
  logic        drop;

  always_comb begin
    dx1 = $signed({1'b0, vx_reg[1]}) - $signed({1'b0, vx_reg[0]});
    dy1 = $signed({1'b0, vy_reg[1]}) - $signed({1'b0, vy_reg[0]});
    dx2 = $signed({1'b0, vx_reg[2]}) - $signed({1'b0, vx_reg[0]});
    dy2 = $signed({1'b0, vy_reg[2]}) - $signed({1'b0, vy_reg[0]});
    prod_a   = 22'(dx1) * 22'(dy2);
    prod_b   = 22'(dx2) * 22'(dy1);
    area     = prod_a - prod_b;
    area_neg = -area;

    min_x = vx_reg[0];
    max_x = vx_reg[0];
    min_y = vy_reg[0];
    max_y = vy_reg[0];
    for (int i = 1; i < 3; i++) begin
      if (vx_reg[i] < min_x) min_x = vx_reg[i];
      if (vx_reg[i] > max_x) max_x = vx_reg[i];
      if (vy_reg[i] < min_y) min_y = vy_reg[i];
      if (vy_reg[i] > max_y) max_y = vy_reg[i];
    end
    clip_xmax = (max_x > X_MAX) ? X_MAX : max_x;
    clip_ymax = (max_y > Y_MAX) ? Y_MAX : max_y;

    drop = (area == '0) || ({1'b0, min_x} >= X_LIM) || ({1'b0, min_y} >= Y_LIM);
    out_data = {vy_reg[2], vx_reg[2], vy_reg[1], vx_reg[1], vy_reg[0], vx_reg[0]};
    area_abs = area[20:0];
`ifdef BACKFACE_CULL_EN
    if (area[21]) drop = 1'b1;
`else
    // Clockwise input: swap vertices 1 and 2 so the output winds counter-clockwise.
    if (area[21]) begin
      out_data = {vy_reg[1], vx_reg[1], vy_reg[2], vx_reg[2], vy_reg[0], vx_reg[0]};
      area_abs = area_neg[20:0];
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg         <= IDLE;
      fifo_rd_en        <= 1'b0;
      tri_out.tri_valid <= 1'b0;
      tri_out.tri_data  <= '0;
      tri_out.bbox_xmin <= '0;
      tri_out.bbox_xmax <= '0;
      tri_out.bbox_ymin <= '0;
      tri_out.bbox_ymax <= '0;
      tri_out.tri_area  <= '0;
      drop_cnt          <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            state_reg  <= READ;
            fifo_rd_en <= 1'b1;
          end
        end
        READ:  state_reg <= WAIT;
        WAIT:  state_reg <= SETUP;
        SETUP: begin
          if (drop) begin
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            state_reg <= IDLE;
          end else begin
            tri_out.tri_data  <= out_data;
            tri_out.bbox_xmin <= min_x;
            tri_out.bbox_xmax <= clip_xmax;
            tri_out.bbox_ymin <= min_y;
            tri_out.bbox_ymax <= clip_ymax;
            tri_out.tri_area  <= area_abs;
            tri_out.tri_valid <= 1'b1;
            state_reg         <= OUT;
          end
        end
        OUT: begin
          if (tri_out.tri_ready) begin
            tri_out.tri_valid <= 1'b0;
            state_reg         <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_setup.sv
module tb_triangle_setup;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [59:0] fifo_data = '0;
  logic [15:0] drop_cnt;

  triangle_setup_if bus ();

  triangle_setup #(.SCREEN_W(640), .SCREEN_H(480), .CNT_W(16)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .tri_out    (bus.master),
    .drop_cnt   (drop_cnt)
  );

  always #5 Clk = ~Clk;

  // FIFO model: 1-clock read latency, pointer advances on each pop.
  logic [59:0] fmem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      fifo_data <= fmem[rd_ptr[4:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [59:0] word;
    bit          drop;
    logic [59:0] exp_data;
    logic [9:0]  xmin, xmax, ymin, ymax;
    logic [20:0] area;
    int          hold;
  } vec_t;

  vec_t vecs [10];
  int   nvec = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_drops = 0;

  function automatic logic [59:0] pk(int x0, int y0, int x1, int y1, int x2, int y2);
    return {10'(y2), 10'(x2), 10'(y1), 10'(x1), 10'(y0), 10'(x0)};
  endfunction

  task automatic add_keep(logic [59:0] w, logic [59:0] ed, int xn, int xx, int yn, int yx,
                          int a, int hold);
    vecs[nvec].word = w;   vecs[nvec].drop = 1'b0; vecs[nvec].exp_data = ed;
    vecs[nvec].xmin = 10'(xn); vecs[nvec].xmax = 10'(xx);
    vecs[nvec].ymin = 10'(yn); vecs[nvec].ymax = 10'(yx);
    vecs[nvec].area = 21'(a);  vecs[nvec].hold = hold;
    nvec++;
  endtask

  task automatic add_drop(logic [59:0] w);
    vecs[nvec].word = w;   vecs[nvec].drop = 1'b1; vecs[nvec].exp_data = '0;
    vecs[nvec].xmin = '0; vecs[nvec].xmax = '0; vecs[nvec].ymin = '0; vecs[nvec].ymax = '0;
    vecs[nvec].area = '0; vecs[nvec].hold = 0;
    nvec++;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(logic [59:0] w);
    fmem[wr_ptr[4:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk_outputs(int idx, string tag);
    chk({tag, " tri_data"},  64'(bus.tri_data),  64'(vecs[idx].exp_data));
    chk({tag, " bbox_xmin"}, 64'(bus.bbox_xmin), 64'(vecs[idx].xmin));
    chk({tag, " bbox_xmax"}, 64'(bus.bbox_xmax), 64'(vecs[idx].xmax));
    chk({tag, " bbox_ymin"}, 64'(bus.bbox_ymin), 64'(vecs[idx].ymin));
    chk({tag, " bbox_ymax"}, 64'(bus.bbox_ymax), 64'(vecs[idx].ymax));
    chk({tag, " tri_area"},  64'(bus.tri_area),  64'(vecs[idx].area));
  endtask

  // Follows one triangle from pop to handshake (or drop); the word must already be queued.
  task automatic observe(int idx);
    int  rd_c = -1;
    int  end_c = -1;
    bit  done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge Clk);
      if (fifo_rd_en) rd_c = cyc;
      if (bus.tri_valid || drop_cnt != 16'(exp_drops)) begin
        end_c = cyc;
        done = 1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL vec%0d timeout: no tri_valid and no drop within 30 cycles", idx);
      return;
    end
    if (vecs[idx].drop) exp_drops++;
    chk($sformatf("vec%0d latency", idx), 64'(end_c - rd_c), 64'd3);
    chk($sformatf("vec%0d tri_valid", idx), 64'(bus.tri_valid), 64'(!vecs[idx].drop));
    chk($sformatf("vec%0d drop_cnt", idx), 64'(drop_cnt), 64'(exp_drops));
    if (vecs[idx].drop) begin
      repeat (3) @(negedge Clk);
      chk($sformatf("vec%0d no late valid", idx), 64'(bus.tri_valid), 64'd0);
    end else begin
      chk_outputs(idx, $sformatf("vec%0d", idx));
      for (int h = 0; h < vecs[idx].hold; h++) begin
        @(negedge Clk);
        chk($sformatf("vec%0d hold%0d valid", idx, h), 64'(bus.tri_valid), 64'd1);
        chk($sformatf("vec%0d hold%0d rd_en", idx, h), 64'(fifo_rd_en), 64'd0);
        chk_outputs(idx, $sformatf("vec%0d hold%0d", idx, h));
      end
      bus.tri_ready = 1'b1;
      @(negedge Clk);
      bus.tri_ready = 1'b0;
      chk($sformatf("vec%0d valid drop after hs", idx), 64'(bus.tri_valid), 64'd0);
    end
    $display("vec%0d word=0x%015h drop=%0d rd_cycle=%0d done_cycle=%0d drop_cnt=%0d",
             idx, vecs[idx].word, vecs[idx].drop, rd_c, end_c, drop_cnt);
  endtask

  initial begin
    bit rd_seen = 0;
    bus.tri_ready = 1'b0;

    // 0: basic CCW, 1: same with stall
    add_keep(pk(10,10,100,10,10,50), pk(10,10,100,10,10,50), 10, 100, 10, 50, 3600, 0);
    add_keep(pk(10,10,100,10,10,50), pk(10,10,100,10,10,50), 10, 100, 10, 50, 3600, 5);
    // 2: collinear
    add_drop(pk(0,0,5,5,10,10));
`ifdef BACKFACE_CULL_EN
    add_drop(pk(10,10,10,50,100,10));
    add_drop(pk(5,7,3,20,30,1));
`else
    // 3: clockwise, A=-3600 -> vertices 1/2 swapped
    add_keep(pk(10,10,10,50,100,10), pk(10,10,100,10,10,50), 10, 100, 10, 50, 3600, 0);
    // 4: clockwise, A=12-325=-313
    add_keep(pk(5,7,3,20,30,1), pk(5,7,30,1,3,20), 3, 30, 1, 20, 313, 1);
`endif
    // 5: x clip, A=10000
    add_keep(pk(600,100,700,100,600,200), pk(600,100,700,100,600,200), 600, 639, 100, 200, 10000, 0);
    // 6: off-screen in x, 7: off-screen in y
    add_drop(pk(650,0,700,0,650,50));
    add_drop(pk(0,480,10,480,0,490));
    // 8: full-range, A=1023*1023, clipped both ways
    add_keep(pk(0,0,1023,0,0,1023), pk(0,0,1023,0,0,1023), 0, 639, 0, 479, 1046529, 0);

    // Reset with empty FIFO
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (fifo_rd_en) rd_seen = 1;
    end
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (fifo_rd_en) rd_seen = 1;
    end
    chk("reset rd_en never", 64'(rd_seen), 64'd0);
    chk("reset tri_valid", 64'(bus.tri_valid), 64'd0);
    chk("reset tri_data", 64'(bus.tri_data), 64'd0);
    chk("reset bbox", 64'({bus.bbox_xmin, bus.bbox_xmax, bus.bbox_ymin, bus.bbox_ymax}), 64'd0);
    chk("reset tri_area", 64'(bus.tri_area), 64'd0);
    chk("reset drop_cnt", 64'(drop_cnt), 64'd0);

    for (int v = 0; v < nvec; v++) begin
      push(vecs[v].word);
      observe(v);
    end

    // Two queued triangles: no second pop while the first is stalled in OUT.
    push(vecs[1].word);
    push(vecs[0].word);
    observe(1);
    observe(0);

    // Reset while a triangle is held in OUT clears everything.
    push(vecs[0].word);
    for (int k = 0; k < 20 && !bus.tri_valid; k++) @(negedge Clk);
    chk("pre-reset valid", 64'(bus.tri_valid), 64'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    exp_drops = 0;
    chk("inflight reset valid", 64'(bus.tri_valid), 64'd0);
    chk("inflight reset area", 64'(bus.tri_area), 64'd0);
    chk("inflight reset drop_cnt", 64'(drop_cnt), 64'd0);
    $display("inflight reset: tri_valid=%0d drop_cnt=%0d", bus.tri_valid, drop_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
